// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared types and constants for the IF-stage fetch sequencer
package if_fetch_ctrl_pkg;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: fetch bus between branch/hazard logic, instruction memory and decode
interface if_fetch_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        misalign;
    modport master (
        input  redirect_valid, redirect_addr, stall, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_pc, id_instr, misalign
    );
    modport slave (
        output redirect_valid, redirect_addr, stall, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_pc, id_instr, misalign
    );
endinterface

// File: rtl/if_fetch_ctrl_fifo.sv
// if_fetch_ctrl_fifo: synchronous fetch buffer with a registered head entry
module if_fetch_ctrl_fifo
    import if_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           wr_en, rd_en;
    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    // storage and pointers; flush empties the buffer without touching stored data
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and fetch sequencer feeding decode through a small buffer
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e  state;
    logic [31:0]   pc;
    logic          inflight;
    logic          misalign_q;
    logic          push, pop, full, empty;
    logic [CW-1:0] count, free_slots;
    fetch_entry_t  head;
    // a redirect flushes the buffer, so it also kills the landing response and any pop
    assign pop        = bus.id_valid && bus.id_ready && !bus.redirect_valid;
    assign push       = inflight && !bus.redirect_valid;
    // a slot freed by this cycle's pop is already usable as credit for a new request
    assign free_slots = CW'(FIFO_DEPTH) - count + CW'(pop);
    assign bus.imem_req  = (state == RUN) && !bus.stall && !bus.redirect_valid &&
                           (free_slots > CW'(inflight));
    assign bus.imem_addr = pc;
    assign bus.id_valid  = !empty;
    assign bus.id_pc     = empty ? '0 : head.pc;
    assign bus.id_instr  = empty ? '0 : head.instr;
    assign bus.misalign  = misalign_q;
    if_fetch_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ('{pc: pc - INSTR_BYTES, instr: bus.imem_rdata}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // sequencer state, program counter, in-flight tracking and misalign pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            inflight   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            inflight   <= bus.imem_req;
            misalign_q <= bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00);
            pc         <= bus.redirect_valid ? {bus.redirect_addr[31:2], 2'b00} :
                          bus.imem_req       ? pc + INSTR_BYTES : pc;
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (!bus.redirect_valid && full && !inflight && !pop) state <= HOLD;
                default: if (bus.redirect_valid || !full) state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus a random stream checked against a queue model
module tb_if_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc, pend_pc;
    logic        exp_mis, pend;
    logic [31:0] qpc[$];
    logic [31:0] qins[$];
    if_fetch_ctrl_if bus ();
    if_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction
    // instruction memory: one-cycle read latency, junk when not requested
    always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : $urandom;
    // reference model: expected next fetch address and buffered {pc, instr} sequence
    always @(posedge clk) begin
        if (!rst_n) begin
            qpc.delete(); qins.delete();
            pend = 1'b0; exp_pc = RESET_PC; exp_mis = 1'b0;
        end else begin
            exp_mis = bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00);
            if (bus.redirect_valid) begin
                qpc.delete(); qins.delete();
                pend = 1'b0;
                exp_pc = {bus.redirect_addr[31:2], 2'b00};
            end else begin
                if (qpc.size() != 0 && bus.id_ready) begin
                    void'(qpc.pop_front()); void'(qins.pop_front());
                end
                if (pend) begin qpc.push_back(pend_pc); qins.push_back(mem_word(pend_pc)); end
                pend = bus.imem_req;
                pend_pc = exp_pc;
                if (bus.imem_req) exp_pc = exp_pc + 32'd4;
            end
        end
    end
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.stall = 1'b0; bus.id_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.stall = 1'b0; bus.id_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.misalign !== 1'b0 ||
            bus.imem_addr !== RESET_PC || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b valid=%b mis=%b addr=%h pc=%h instr=%h want 0 0 0 %h 0 0",
                     bus.imem_req, bus.id_valid, bus.misalign, bus.imem_addr, bus.id_pc, bus.id_instr, RESET_PC);
        end
    endtask
    task automatic test_boot_stream();
        do_reset();
        bus.id_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req !== (c >= 1)) begin
                errors++; $display("FAIL boot_req c%0d got %b want %b", c, bus.imem_req, c >= 1);
            end
            if (c >= 1) begin
                checks++;
                if (bus.imem_addr !== 32'(4 * (c - 1))) begin
                    errors++; $display("FAIL boot_addr c%0d got %h want %h", c, bus.imem_addr, 32'(4 * (c - 1)));
                end
            end
            checks++;
            if (bus.id_valid !== (c >= 3)) begin
                errors++; $display("FAIL boot_valid c%0d got %b want %b", c, bus.id_valid, c >= 3);
            end
            if (c >= 3) begin
                checks++;
                if (bus.id_pc !== 32'(4 * (c - 3)) || bus.id_instr !== mem_word(32'(4 * (c - 3)))) begin
                    errors++; $display("FAIL boot_head c%0d got %h/%h want %h/%h", c, bus.id_pc, bus.id_instr,
                                       32'(4 * (c - 3)), mem_word(32'(4 * (c - 3))));
                end
            end
        end
    endtask
    task automatic test_backpressure();
        int nreq = 0;
        int npop = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                checks++;
                if (bus.imem_addr !== 32'(4 * nreq)) begin
                    errors++; $display("FAIL bp_addr got %h want %h", bus.imem_addr, 32'(4 * nreq));
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != DEPTH) begin errors++; $display("FAIL bp_req_count got %0d want %0d", nreq, DEPTH); end
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head got %b/%h want 1/00000000", bus.id_valid, bus.id_pc);
        end
        step();
        bus.id_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.id_valid) begin
                checks++;
                if (bus.id_pc !== 32'(4 * npop)) begin
                    errors++; $display("FAIL bp_resume got %h want %h", bus.id_pc, 32'(4 * npop));
                end
                npop++;
            end
        end
        checks++;
        if (npop < 5) begin errors++; $display("FAIL bp_resume_count got %0d want >=5", npop); end
    endtask
    task automatic test_redirect();
        do_reset();
        bus.id_ready = 1'b1;
        repeat (4) step();
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_same_req got %b want 0", bus.imem_req); end
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.id_valid !== 1'b0 || bus.misalign !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_next got valid=%b mis=%b req=%b addr=%h want 0 0 1 00000100",
                               bus.id_valid, bus.misalign, bus.imem_req, bus.imem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got valid=%b pc=%h want 0", bus.id_valid, bus.id_pc); end
        step(); @(negedge clk);
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== mem_word(32'h100)) begin
            errors++; $display("FAIL redir_head got %b/%h/%h want 1/00000100/%h", bus.id_valid, bus.id_pc,
                               bus.id_instr, mem_word(32'h100));
        end
    endtask
    task automatic test_misalign();
        do_reset();
        bus.id_ready = 1'b1;
        repeat (2) step();
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h103;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.misalign !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL mis_pulse got mis=%b req=%b addr=%h want 1 1 00000100", bus.misalign, bus.imem_req, bus.imem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL mis_width got %b want 0", bus.misalign); end
        step(); @(negedge clk);
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100) begin
            errors++; $display("FAIL mis_head got %b/%h want 1/00000100", bus.id_valid, bus.id_pc);
        end
    endtask
    task automatic test_stall();
        int npop = 0;
        do_reset();
        bus.id_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            bus.stall = (c >= 5 && c <= 7);
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                checks++;
                if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d got %b want 0", c, bus.imem_req); end
            end
            if (c == 6) begin
                checks++;
                if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hC) begin
                    errors++; $display("FAIL stall_inflight got %b/%h want 1/0000000c", bus.id_valid, bus.id_pc);
                end
            end
            if (bus.id_valid) begin
                checks++;
                if (bus.id_pc !== 32'(4 * npop)) begin
                    errors++; $display("FAIL stall_order got %h want %h", bus.id_pc, 32'(4 * npop));
                end
                npop++;
            end
            step();
        end
        bus.stall = 1'b0;
        checks++;
        if (npop < 10) begin errors++; $display("FAIL stall_count got %0d want >=10", npop); end
    endtask
    task automatic test_wrap();
        do_reset();
        bus.id_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b1; bus.redirect_addr = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first got %b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (bus.id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head0 got %h want fffffffc", bus.id_pc); end
        step(); @(negedge clk);
        checks++;
        if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL wrap_head1 got %h want 00000000", bus.id_pc); end
    endtask
    task automatic test_reset_midflight();
        do_reset();
        bus.id_ready = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        step(); @(negedge clk);
        checks++;
        if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || bus.id_pc !== 32'h0) begin
            errors++; $display("FAIL midrst_hold got valid=%b req=%b addr=%h pc=%h want 0 0 %h 0",
                               bus.id_valid, bus.imem_req, bus.imem_addr, bus.id_pc, RESET_PC);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.id_valid !== (c >= 3) || (c == 1 && (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC))) begin
                errors++; $display("FAIL midrst_restart c%0d got valid=%b req=%b addr=%h", c, bus.id_valid, bus.imem_req, bus.imem_addr);
            end
            if (c == 3) begin
                checks++;
                if (bus.id_pc !== RESET_PC) begin errors++; $display("FAIL midrst_head got %h want %h", bus.id_pc, RESET_PC); end
            end
        end
    endtask
    task automatic test_random_stream();
        int npop = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.id_ready       = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rst_n              = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            checks++;
            if (bus.id_valid !== (qpc.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, bus.id_valid, qpc.size() != 0);
            end
            if (qpc.size() != 0) begin
                checks++;
                if (bus.id_pc !== qpc[0] || bus.id_instr !== qins[0]) begin
                    errors++; $display("FAIL rnd_head c%0d got %h/%h want %h/%h", c, bus.id_pc, bus.id_instr, qpc[0], qins[0]);
                end
            end
            if (bus.imem_req) begin
                checks++;
                if (bus.stall || bus.redirect_valid || bus.imem_addr !== exp_pc) begin
                    errors++; $display("FAIL rnd_req c%0d got addr=%h stall=%b redir=%b want addr=%h no stall/redir",
                                       c, bus.imem_addr, bus.stall, bus.redirect_valid, exp_pc);
                end
            end
            checks++;
            if (bus.misalign !== exp_mis) begin
                errors++; $display("FAIL rnd_misalign c%0d got %b want %b", c, bus.misalign, exp_mis);
            end
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) npop++;
            step();
        end
        rst_n = 1'b1; bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        checks++;
        if (npop < 100) begin errors++; $display("FAIL rnd_progress got %0d pops want >=100", npop); end
    endtask
    initial begin
        test_reset();
        test_boot_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_stall();
        test_wrap();
        test_reset_midflight();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
